// File: rtl/clock_pkg.sv
// Shared definitions for the clock set-mode controller: mode encodings,
// millisecond timing defaults and a counter-width helper.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_SET_SEC  = 2'd3
  } set_mode_e;

  localparam int DEF_CLK_HZ        = 100_000_000;
  localparam int DEF_REPEAT_DLY_MS = 500;
  localparam int DEF_REPEAT_PER_MS = 100;
  localparam int DEF_TIMEOUT_MS    = 10_000;
  localparam int DEF_BLINK_MS      = 250;

  // Bits needed to hold the value v itself (a down-counter loaded with v).
  function automatic int cnt_width(input int v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction

  function automatic set_mode_e next_mode(input set_mode_e m);
    case (m)
      MODE_RUN:      return MODE_SET_HOUR;
      MODE_SET_HOUR: return MODE_SET_MIN;
      MODE_SET_MIN:  return MODE_SET_SEC;
      default:       return MODE_RUN;
    endcase
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every millisecond.
module ms_tick_gen
  import clock_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int DIV = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
  localparam int W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] TC = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == TC) ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == TC);

endmodule

// File: rtl/clock_set_ctrl.sv
// Set-mode controller for a clock display: mode/inc key handling, auto-repeat,
// idle timeout and blink gate. States: RUN (timekeeping) | SET_HOUR | SET_MIN | SET_SEC.
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ        = DEF_CLK_HZ,
  parameter int REPEAT_DLY_MS = DEF_REPEAT_DLY_MS,
  parameter int REPEAT_PER_MS = DEF_REPEAT_PER_MS,
  parameter int TIMEOUT_MS    = DEF_TIMEOUT_MS,
  parameter int BLINK_MS      = DEF_BLINK_MS
) (
  input  logic       XTAL_OSC,
  input  logic       rst,
  input  logic       key_flag,
  input  logic       mode_key,
  input  logic       inc_key,
  output logic [1:0] set_mode,
  output logic       run_en,
  output logic       hour_inc,
  output logic       min_inc,
  output logic       sec_clr,
  output logic       blink
);

  localparam int RPT_MAX = (REPEAT_DLY_MS > REPEAT_PER_MS) ? REPEAT_DLY_MS : REPEAT_PER_MS;
  localparam int RPT_W   = cnt_width(RPT_MAX);
  localparam int TO_W    = cnt_width(TIMEOUT_MS);
  localparam int BLK_W   = cnt_width(BLINK_MS);

  localparam logic [RPT_W-1:0] RPT_DLY = RPT_W'(REPEAT_DLY_MS);
  localparam logic [RPT_W-1:0] RPT_PER = RPT_W'(REPEAT_PER_MS);
  localparam logic [TO_W-1:0]  TO_LD   = TO_W'(TIMEOUT_MS);
  localparam logic [BLK_W-1:0] BLK_LD  = BLK_W'(BLINK_MS);

  set_mode_e        state_q, state_d;
  logic             mode_prev_q, mode_prev_d;
  logic             inc_prev_q, inc_prev_d;
  logic             rpt_act_q, rpt_act_d;
  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_q, blink_d;
  logic             hour_inc_q, hour_inc_d;
  logic             min_inc_q, min_inc_d;
  logic             sec_clr_q, sec_clr_d;

  logic ms_tick;
  logic mode_press, inc_press, inc_rel;
  logic in_set, can_rpt, auto_fire, timeout, pulse;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_ms_tick (
    .clk_i  (XTAL_OSC),
    .rst_i  (rst),
    .tick_o (ms_tick)
  );

  always_comb begin
    mode_press  = key_flag & ~mode_key & mode_prev_q;
    // A simultaneous mode press swallows the inc press entirely.
    inc_press   = key_flag & ~inc_key & inc_prev_q & ~mode_press;
    inc_rel     = key_flag & inc_key;
    mode_prev_d = key_flag ? mode_key : mode_prev_q;
    inc_prev_d  = key_flag ? inc_key  : inc_prev_q;

    in_set    = (state_q != MODE_RUN);
    can_rpt   = (state_q == MODE_SET_HOUR) || (state_q == MODE_SET_MIN);
    auto_fire = rpt_act_q & ms_tick & (rpt_cnt_q == RPT_W'(1)) & ~mode_press & ~inc_rel;
    timeout   = in_set & ms_tick & (to_cnt_q == TO_W'(1)) & ~mode_press & ~inc_press & ~auto_fire;

    state_d = state_q;
    if (mode_press)   state_d = next_mode(state_q);
    else if (timeout) state_d = MODE_RUN;

    pulse      = (inc_press & in_set) | auto_fire;
    hour_inc_d = pulse & (state_q == MODE_SET_HOUR);
    min_inc_d  = pulse & (state_q == MODE_SET_MIN);
    sec_clr_d  = pulse & (state_q == MODE_SET_SEC);

    rpt_act_d = rpt_act_q;
    rpt_cnt_d = rpt_cnt_q;
    if (mode_press | timeout | inc_rel) begin
      rpt_act_d = 1'b0;
      rpt_cnt_d = '0;
    end else if (inc_press & can_rpt) begin
      rpt_act_d = 1'b1;
      rpt_cnt_d = RPT_DLY;
    end else if (rpt_act_q & ms_tick) begin
      rpt_cnt_d = (rpt_cnt_q == RPT_W'(1)) ? RPT_PER : rpt_cnt_q - RPT_W'(1);
    end

    to_cnt_d = to_cnt_q;
    if (state_d == MODE_RUN)                   to_cnt_d = '0;
    else if (mode_press | inc_press | auto_fire) to_cnt_d = TO_LD;
    else if (ms_tick)                          to_cnt_d = to_cnt_q - TO_W'(1);

    // Blink phase restarts high on every entry into a set state.
    blink_d   = blink_q;
    blk_cnt_d = blk_cnt_q;
    if (state_d == MODE_RUN) begin
      blink_d   = 1'b1;
      blk_cnt_d = '0;
    end else if (state_d != state_q) begin
      blink_d   = 1'b1;
      blk_cnt_d = BLK_LD;
    end else if (ms_tick) begin
      if (blk_cnt_q == BLK_W'(1)) begin
        blink_d   = ~blink_q;
        blk_cnt_d = BLK_LD;
      end else begin
        blk_cnt_d = blk_cnt_q - BLK_W'(1);
      end
    end
  end

  always_ff @(posedge XTAL_OSC) begin
    if (rst) begin
      state_q     <= MODE_RUN;
      mode_prev_q <= 1'b1;
      inc_prev_q  <= 1'b1;
      rpt_act_q   <= 1'b0;
      rpt_cnt_q   <= '0;
      to_cnt_q    <= '0;
      blk_cnt_q   <= '0;
      blink_q     <= 1'b1;
      hour_inc_q  <= 1'b0;
      min_inc_q   <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= mode_prev_d;
      inc_prev_q  <= inc_prev_d;
      rpt_act_q   <= rpt_act_d;
      rpt_cnt_q   <= rpt_cnt_d;
      to_cnt_q    <= to_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      blink_q     <= blink_d;
      hour_inc_q  <= hour_inc_d;
      min_inc_q   <= min_inc_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  assign set_mode = state_q;
  assign run_en   = (state_q == MODE_RUN);
  assign hour_inc = hour_inc_q;
  assign min_inc  = min_inc_q;
  assign sec_clr  = sec_clr_q;
  assign blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: directed scenarios plus random key traffic, every
// cycle compared against a timestamp-based reference model.
module tb_clock_set_ctrl;

  localparam int CLK_HZ = 10_000;
  localparam int DIV    = CLK_HZ / 1000;
  localparam int DLY    = 5;
  localparam int PER    = 2;
  localparam int TO     = 20;
  localparam int BLK    = 3;

  logic       XTAL_OSC;
  logic       rst, key_flag, mode_key, inc_key;
  logic [1:0] set_mode;
  logic       run_en, hour_inc, min_inc, sec_clr, blink;

  clock_set_ctrl #(
    .CLK_HZ(CLK_HZ), .REPEAT_DLY_MS(DLY), .REPEAT_PER_MS(PER),
    .TIMEOUT_MS(TO), .BLINK_MS(BLK)
  ) dut (
    .XTAL_OSC (XTAL_OSC),
    .rst      (rst),
    .key_flag (key_flag),
    .mode_key (mode_key),
    .inc_key  (inc_key),
    .set_mode (set_mode),
    .run_en   (run_en),
    .hour_inc (hour_inc),
    .min_inc  (min_inc),
    .sec_clr  (sec_clr),
    .blink    (blink)
  );

  initial begin
    XTAL_OSC = 1'b0;
    forever #5 XTAL_OSC = ~XTAL_OSC;
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: time measured in elapsed ms ticks, events as timestamps.
  int m_n, m_ms, m_mode, m_rpt_start, m_last_act, m_entry;
  bit m_mprev, m_iprev, m_rpt_on;
  bit e_h, e_m, e_s, e_blink;

  task automatic model_edge(input bit r, input bit kf, input bit mk, input bit ik);
    bit tick, mp, ip, ir, auto_p, tout;
    int old, el;
    if (r) begin
      m_n = 0; m_ms = 0; m_mode = 0; m_mprev = 1; m_iprev = 1; m_rpt_on = 0;
      m_rpt_start = 0; m_last_act = 0; m_entry = 0;
      e_h = 0; e_m = 0; e_s = 0; e_blink = 1;
      return;
    end
    m_n++;
    tick = (m_n % DIV) == 0;
    if (tick) m_ms++;
    mp = kf && !mk && m_mprev;
    ip = kf && !ik && m_iprev && !mp;
    ir = kf && ik;
    if (kf) begin m_mprev = mk; m_iprev = ik; end
    old = m_mode;
    auto_p = 0;
    if (m_rpt_on && tick && !mp && !ir) begin
      el = m_ms - m_rpt_start;
      auto_p = (el >= DLY) && (((el - DLY) % PER) == 0);
    end
    tout = (old != 0) && tick && !mp && !ip && !auto_p && ((m_ms - m_last_act) == TO);
    e_h = (ip || auto_p) && old == 1;
    e_m = (ip || auto_p) && old == 2;
    e_s = ip && old == 3;
    if (mp) begin
      m_mode = (old + 1) % 4; m_entry = m_ms; m_last_act = m_ms; m_rpt_on = 0;
    end else if (tout) begin
      m_mode = 0; m_rpt_on = 0;
    end else begin
      if (ir) m_rpt_on = 0;
      else if (ip && (old == 1 || old == 2)) begin m_rpt_on = 1; m_rpt_start = m_ms; end
      if (ip || auto_p) m_last_act = m_ms;
    end
    e_blink = (m_mode == 0) ? 1'b1 : (((m_ms - m_entry) / BLK) % 2 == 0);
  endtask

  bit mode_lvl = 1, inc_lvl = 1;
  int cnt_h, cnt_m, cnt_s;

  task automatic step(input bit r, input bit kf);
    rst = r; key_flag = kf; mode_key = mode_lvl; inc_key = inc_lvl;
    @(posedge XTAL_OSC);
    model_edge(r, kf, mode_lvl, inc_lvl);
    @(negedge XTAL_OSC);
    chk_eq("set_mode", int'(set_mode), m_mode);
    chk_eq("run_en",   int'(run_en),   int'(m_mode == 0));
    chk_eq("hour_inc", int'(hour_inc), int'(e_h));
    chk_eq("min_inc",  int'(min_inc),  int'(e_m));
    chk_eq("sec_clr",  int'(sec_clr),  int'(e_s));
    chk_eq("blink",    int'(blink),    int'(e_blink));
    chk_eq("one_pulse", int'((int'(hour_inc) + int'(min_inc) + int'(sec_clr)) <= 1), 1);
    cnt_h += int'(hour_inc); cnt_m += int'(min_inc); cnt_s += int'(sec_clr);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0);
  endtask

  task automatic keys(input bit m, input bit i);
    mode_lvl = m; inc_lvl = i;
    step(0, 1);
  endtask

  task automatic mode_tap();
    keys(0, inc_lvl); idle(2);
    keys(1, inc_lvl); idle(2);
  endtask

  task automatic clr_cnt();
    cnt_h = 0; cnt_m = 0; cnt_s = 0;
  endtask

  initial begin
    bit r, kf;
    rst = 1; key_flag = 0; mode_key = 1; inc_key = 1;
    repeat (3) step(1, 0);
    chk_eq("rst_mode", int'(set_mode), 0);
    chk_eq("rst_run_en", int'(run_en), 1);
    chk_eq("rst_blink", int'(blink), 1);
    idle(4);

    // Mode cycling
    for (int k = 1; k <= 4; k++) begin
      keys(0, 1);
      chk_eq("mode_seq", int'(set_mode), k % 4);
      chk_eq("run_en_seq", int'(run_en), int'((k % 4) == 0));
      idle(2); keys(1, 1); idle(2);
    end

    // SET_MIN auto-repeat, 12 ms hold
    mode_tap(); mode_tap();
    clr_cnt();
    keys(1, 0); idle(119); keys(1, 1);
    chk_eq("min_rpt_cnt", cnt_m, 5);
    chk_eq("min_rpt_no_hour", cnt_h, 0);
    clr_cnt(); idle(30);
    chk_eq("min_after_rel", cnt_m, 0);

    // SET_SEC never repeats
    mode_tap();
    clr_cnt();
    keys(1, 0); idle(119); keys(1, 1);
    chk_eq("sec_clr_cnt", cnt_s, 1);
    mode_tap();
    chk_eq("back_to_run", int'(set_mode), 0);

    // Idle timeout from SET_HOUR
    mode_tap(); idle(150);
    chk_eq("pre_timeout", int'(set_mode), 1);
    idle(50);
    chk_eq("timeout_mode", int'(set_mode), 0);
    chk_eq("timeout_run_en", int'(run_en), 1);
    chk_eq("timeout_blink", int'(blink), 1);

    // Mode and inc on the same key_flag
    mode_tap(); clr_cnt();
    keys(0, 0);
    chk_eq("both_mode", int'(set_mode), 2);
    idle(10);
    chk_eq("both_no_hour", cnt_h, 0);
    chk_eq("both_no_min", cnt_m, 0);
    keys(1, 1); idle(2);
    mode_tap(); mode_tap();

    // Reset in the middle of a SET_HOUR repeat hold
    mode_tap(); clr_cnt();
    keys(1, 0); idle(30);
    chk_eq("hold_first_pulse", cnt_h, 1);
    clr_cnt();
    step(1, 0);
    chk_eq("rst_abort_mode", int'(set_mode), 0);
    chk_eq("rst_abort_pulse", int'(hour_inc), 0);
    idle(80);
    chk_eq("rst_no_hour", cnt_h, 0);
    keys(1, 1); idle(5);

    // Random key traffic with rare resets
    for (int c = 0; c < 4000; c++) begin
      r  = ($urandom_range(0, 999) == 0);
      kf = ($urandom_range(0, 39) == 0);
      if (kf) begin
        if ($urandom_range(0, 1) == 1) mode_lvl = ~mode_lvl;
        if ($urandom_range(0, 1) == 1) inc_lvl = ~inc_lvl;
      end
      step(r, kf);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
